// File: rtl/hs4_pkg.sv
// Shared types and default sizing for the 4-phase async-to-sync sink.
package hs4_pkg;
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEPTH       = 2;
endpackage

// File: rtl/hs4_sync.sv
// Flop-chain synchronizer for a single async level; latency STAGES clocks, no backpressure.
module hs4_sync
    import hs4_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_sink.sv
// Clocked exit of the 4-phase pipeline: req to push/ack in SYNC_STAGES+1 clocks, FWFT FIFO out.
// Backpressure upstream by withholding ack while full; downstream via valid/ready.
module hs4_sink
    import hs4_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ack_o,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic              req_s;
    hs_state_t         state;
    hs_state_t         state_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    hs4_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (req_i),
        .q   (req_s)
    );

    // Full uses the registered count only: a same-cycle pop never frees room for a push.
    assign full    = (count == FULL_CNT);
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign data_o  = mem[rd_ptr];
    assign level_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HS_IDLE: if (req_s && !full) state_nxt = HS_ACK;
            HS_ACK:  if (!req_s)         state_nxt = HS_IDLE;
            default: state_nxt = HS_IDLE;
        endcase
    end

    // The enum is one bit, so ack_o is the state flop itself.
    always_comb begin
        push  = 1'b0;
        ack_o = 1'b0;
        case (state)
            HS_IDLE: push  = req_s && !full;
            HS_ACK:  ack_o = 1'b1;
            default: ack_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hs4_sink.sv
// Drives hs4_sink with a 4-phase async sender model and checks captured words against a queue reference.
module tb_hs4_sink;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] data_i;
    logic        ack_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic [1:0]  level_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          max_level;

    hs4_sink #(
        .DATA_W      (32),
        .SYNC_STAGES (2),
        .DEPTH       (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs only change 1ns after a rising edge, so at the falling edge
    // valid_o && ready_i means the next rising edge pops data_o.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) got_q.push_back(data_o);
        if (int'(level_o) > max_level) max_level = int'(level_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Async upstream stage: raise req with settled data, wait for ack, return to zero.
    task automatic send_token(input logic [31:0] d);
        int n;
        data_i = d;
        req_i  = 1'b1;
        exp_q.push_back(d);
        n = 0;
        while (ack_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (ack_o !== 1'b1) begin
            bad++;
            $display("FAIL send_ack_rise: ack_o=%b want 1 within 20 clocks", ack_o);
        end
        data_i = $urandom;
        repeat ($urandom_range(0, 2)) tick();
        req_i = 1'b0;
        n = 0;
        while (ack_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (ack_o !== 1'b0) begin
            bad++;
            $display("FAIL send_ack_fall: ack_o=%b want 0 within 20 clocks", ack_o);
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic release_req();
        int n;
        req_i = 1'b0;
        n = 0;
        while (ack_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (ack_o !== 1'b0) begin
            bad++;
            $display("FAIL release_ack_fall: ack_o=%b want 0", ack_o);
        end
    endtask

    task automatic drain();
        ready_i = 1'b1;
        repeat (4) tick();
        ready_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; ready_i = 1'b0; data_i = $urandom;
        repeat (3) tick();
        total += 4;
        if (ack_o !== 1'b0)    begin bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        if (valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        if (data_o !== 32'h0)  begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        if (level_o !== 2'd0)  begin bad++; $display("FAIL reset_level: got %0d want 0", level_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_token();
        got_q.delete(); exp_q.delete();
        data_i = 32'hDEADBEEF;
        req_i  = 1'b1;
        tick(); tick();
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL single_ack_early: got %b want 0 after edge 2", ack_o); end
        tick();
        total += 4;
        if (ack_o !== 1'b1)          begin bad++; $display("FAIL single_ack_edge3: got %b want 1", ack_o); end
        if (valid_o !== 1'b1)        begin bad++; $display("FAIL single_valid: got %b want 1", valid_o); end
        if (data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", data_o); end
        if (level_o !== 2'd1)        begin bad++; $display("FAIL single_level: got %0d want 1", level_o); end
        repeat (3) tick();
        total++;
        if (level_o !== 2'd1) begin bad++; $display("FAIL single_one_push: level %0d want 1", level_o); end
        req_i = 1'b0;
        tick(); tick();
        total++;
        if (ack_o !== 1'b1) begin bad++; $display("FAIL single_ack_hold: got %b want 1", ack_o); end
        tick();
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL single_ack_rtz: got %b want 0", ack_o); end
        drain();
        total += 2;
        if (got_q.size() !== 1) begin bad++; $display("FAIL single_pop_count: got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_pop_data: got %h want deadbeef", got_q[0]); end
        if (level_o !== 2'd0) begin bad++; $display("FAIL single_drained: level %0d want 0", level_o); end
    endtask

    task automatic test_backpressure();
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        send_token(32'h1);
        send_token(32'h2);
        total++;
        if (level_o !== 2'd2) begin bad++; $display("FAIL bp_level_full: got %0d want 2", level_o); end
        data_i = 32'h3; req_i = 1'b1; exp_q.push_back(32'h3);
        repeat (6) tick();
        total += 2;
        if (ack_o !== 1'b0)   begin bad++; $display("FAIL bp_ack_withheld: got %b want 0", ack_o); end
        if (level_o !== 2'd2) begin bad++; $display("FAIL bp_level_hold: got %0d want 2", level_o); end
        ready_i = 1'b1;
        tick();
        total += 2;
        if (ack_o !== 1'b0)   begin bad++; $display("FAIL bp_no_push_on_pop: ack %b want 0", ack_o); end
        if (level_o !== 2'd1) begin bad++; $display("FAIL bp_level_after_pop: got %0d want 1", level_o); end
        tick();
        total += 2;
        if (ack_o !== 1'b1)   begin bad++; $display("FAIL bp_third_ack: got %b want 1", ack_o); end
        if (level_o !== 2'd1) begin bad++; $display("FAIL bp_push_pop_level: got %0d want 1", level_o); end
        release_req();
        drain();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_streaming();
        got_q.delete(); exp_q.delete();
        ready_i = 1'b1;
        max_level = 0;
        for (int k = 0; k < 8; k++) send_token($urandom);
        repeat (3) tick();
        ready_i = 1'b0;
        total += 2;
        if (max_level > 1) begin bad++; $display("FAIL stream_level: max %0d want <=1", max_level); end
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] w;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        send_token($urandom);
        send_token($urandom);
        w = $urandom;
        data_i = w; req_i = 1'b1; exp_q.push_back(w);
        repeat (3) tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total += 2;
        if (level_o !== 2'd1) begin bad++; $display("FAIL fullpop_level: got %0d want 1", level_o); end
        if (ack_o !== 1'b0)   begin bad++; $display("FAIL fullpop_no_push: ack %b want 0", ack_o); end
        tick();
        total += 2;
        if (level_o !== 2'd2) begin bad++; $display("FAIL fullpop_next_push: level %0d want 2", level_o); end
        if (ack_o !== 1'b1)   begin bad++; $display("FAIL fullpop_next_ack: ack %b want 1", ack_o); end
        release_req();
        drain();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL fullpop_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        send_token($urandom);
        for (int k = 0; k < 4; k++) begin
            send_token($urandom);
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
        end
        drain();
        total++;
        if (got_q.size() !== 5) begin
            bad++; $display("FAIL wrap_count: got %0d want 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] w;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        w = $urandom;
        data_i = w; req_i = 1'b1;
        repeat (3) tick();
        total++;
        if (ack_o !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_ack: got %b want 1", ack_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total += 3;
        if (ack_o !== 1'b0)   begin bad++; $display("FAIL rst_mid_ack: got %b want 0", ack_o); end
        if (level_o !== 2'd0) begin bad++; $display("FAIL rst_mid_level: got %0d want 0", level_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        tick(); tick();
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL rst_mid_early: ack %b want 0", ack_o); end
        tick();
        total += 3;
        if (ack_o !== 1'b1)   begin bad++; $display("FAIL rst_mid_recap_ack: got %b want 1", ack_o); end
        if (level_o !== 2'd1) begin bad++; $display("FAIL rst_mid_recap_level: got %0d want 1", level_o); end
        if (data_o !== w)     begin bad++; $display("FAIL rst_mid_recap_data: got %h want %h", data_o, w); end
        release_req();
        drain();
    endtask

    initial begin
        test_reset();
        test_single_token();
        test_backpressure();
        test_streaming();
        test_full_pop();
        test_wrap();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
